// File: rtl/game_pkg.sv
// Shared game display types: screen geometry defaults, pixel type, scan-out
// state encoding and the column-major framebuffer index helper.
package game_pkg;

    localparam int SCR_W = 30;
    localparam int SCR_H = 30;
    localparam int PIX_W = 24;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

    // Framebuffer is column-major: pixel (x,y) lives at x*h+y.
    function automatic int pix_index(input int x, input int y, input int h);
        return x * h + y;
    endfunction

endpackage

// File: rtl/screen_scanout_raster_counter.sv
// Raster x/y position counter for the scan-out: x inner, y outer, both wrap
// at the screen edge; last flags the bottom-right pixel.
module raster_counter #(
    parameter int SCR_W = game_pkg::SCR_W,
    parameter int SCR_H = game_pkg::SCR_H,
    localparam int XW = (SCR_W > 1) ? $clog2(SCR_W) : 1,
    localparam int YW = (SCR_H > 1) ? $clog2(SCR_H) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          adv,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);
    import game_pkg::*;

    localparam logic [XW-1:0] X_MAX = XW'(SCR_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(SCR_H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/screen_scanout.sv
// Framebuffer scan-out: streams one frame in raster order over valid/ready
// with SOF/EOL/EOF markers. SCANOUT_DOUBLE_BUF_EN adds a tear-free shadow copy.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | clear raster position, fetch first pixel (and capture shadow)
// STREAM | presenting beats, advance on accept
// DONE   | frame_done pulse, then IDLE (or LOAD when CONTINUOUS)
module screen_scanout #(
    parameter int SCR_W      = game_pkg::SCR_W,
    parameter int SCR_H      = game_pkg::SCR_H,
    parameter int PIX_W      = game_pkg::PIX_W,
    parameter int CONTINUOUS = 0,
    localparam int XW = (SCR_W > 1) ? $clog2(SCR_W) : 1,
    localparam int YW = (SCR_H > 1) ? $clog2(SCR_H) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SCR_W*SCR_H*PIX_W-1:0] screen,
    input  logic                         start,
    output logic                         busy,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [PIX_W-1:0]             pix_data,
    output logic [XW-1:0]                pix_x,
    output logic [YW-1:0]                pix_y,
    output logic                         pix_sof,
    output logic                         pix_eol,
    output logic                         pix_eof,
    output logic                         frame_done
);
    import game_pkg::*;

    localparam int NPIX = SCR_W * SCR_H;
    localparam logic [XW-1:0] X_MAX = XW'(SCR_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(SCR_H - 1);

    scan_state_t state_q, state_d;

    logic [XW-1:0]         cnt_x;
    logic [YW-1:0]         cnt_y;
    logic                  cnt_last;
    logic                  accept;
    logic                  cnt_clr;
    logic                  cnt_adv;
    logic [XW-1:0]         next_x;
    logic [YW-1:0]         next_y;
    int                    sel_idx;
    logic [NPIX*PIX_W-1:0] src;
    logic [PIX_W-1:0]      pix_data_q, pix_data_d;

    assign accept  = pix_valid && pix_ready;
    assign cnt_clr = (state_q == LOAD);
    assign cnt_adv = (state_q == STREAM) && accept && !cnt_last;

    raster_counter #(
        .SCR_W (SCR_W),
        .SCR_H (SCR_H)
    ) u_raster (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .adv   (cnt_adv),
        .x     (cnt_x),
        .y     (cnt_y),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = STREAM;
            STREAM:  if (accept && cnt_last) state_d = DONE;
            DONE:    state_d = (CONTINUOUS != 0) ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        pix_valid  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            LOAD: begin
                busy = 1'b1;
            end
            STREAM: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef SCANOUT_DOUBLE_BUF_EN
    logic [NPIX*PIX_W-1:0] shadow_q;

    always_ff @(posedge clk) begin
        if (state_q == LOAD) begin
            shadow_q <= screen;
        end
    end

    // Shadow is still being written during LOAD, so the first pixel comes
    // straight from the screen that is being captured.
    assign src = (state_q == LOAD) ? screen : shadow_q;
`else
    assign src = screen;
`endif

    // Position of the beat that follows the current one, wrapped in-range.
    always_comb begin
        next_x = cnt_x + 1'b1;
        next_y = cnt_y;
        if (cnt_x == X_MAX) begin
            next_x = '0;
            next_y = (cnt_y == Y_MAX) ? '0 : cnt_y + 1'b1;
        end
    end

    always_comb begin
        sel_idx    = (state_q == LOAD) ? 0 : pix_index(int'(next_x), int'(next_y), SCR_H);
        pix_data_d = pix_data_q;
        if ((state_q == LOAD) || cnt_adv) begin
            pix_data_d = src[sel_idx*PIX_W +: PIX_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_data_q <= '0;
        end else begin
            pix_data_q <= pix_data_d;
        end
    end

    assign pix_data = pix_data_q;
    assign pix_x    = cnt_x;
    assign pix_y    = cnt_y;
    assign pix_sof  = pix_valid && (cnt_x == '0) && (cnt_y == '0);
    assign pix_eol  = pix_valid && (cnt_x == X_MAX);
    assign pix_eof  = pix_valid && cnt_last;

endmodule
